ram_master: RTL and testbench

- Initiator for the single-port RAM's change-detect handshake.
- Accepts one request at a time from a valid/ready front end (CPU or cache side) and drives ram_data/ram_addr/ram_wr.
- Sequences each request through the RAM's "response falls, then rises" acknowledge, and returns read data or completion on a one-cycle response strobe.
- Guarantees every transaction presents a change in data or wr, since the RAM detects new requests only on those two signals.

---
 rtl/ram_if_pkg.sv | 31 +++
 rtl/ram_master_if.sv | 39 +++
 rtl/ram_phase_timer.sv | 33 +++
 rtl/ram_master.sv | 185 ++++++++++++++++++
 tb/tb_ram_master.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_if_pkg.sv
// Shared types and constants for the change-detect RAM initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default bus widths, RAM response encodings,
// and a helper that tells which states wait on the RAM.
package ram_if_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    // ram_response levels: the RAM drops the line when it latches a new
    // request and raises it again once the operation has been performed.
    localparam logic RAM_RESP_BUSY = 1'b0;
    localparam logic RAM_RESP_DONE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_LOW  = 3'd1,
        P_HIGH = 3'd2,
        W_LOW  = 3'd3,
        W_HIGH = 3'd4,
        RESP   = 3'd5
    } state_t;

    // States in which the controller is waiting on a RAM phase and the
    // phase timer must run.
    function automatic logic is_wait_state(input state_t s);
        return (s == P_LOW) || (s == P_HIGH) || (s == W_LOW) || (s == W_HIGH);
    endfunction

endpackage

// File: rtl/ram_master_if.sv
// Bundle of the request/response front end and the RAM-side bus.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the front end; the RAM side is paced by ram_response.
// Ports: master = controller view (drives req_ready, rsp_*, ram_data/addr/wr);
//        slave  = environment view (drives req_*, ram_response, ram_out).
interface ram_master_if
    import ram_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic              ram_response;
    logic [DATA_W-1:0] ram_out;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, ram_response, ram_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_data, ram_addr, ram_wr
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, ram_response, ram_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_data, ram_addr, ram_wr
    );

endinterface

// File: rtl/ram_phase_timer.sv
// Watchdog for a single RAM phase: counts cycles while enabled, restarts on clear.
// Latency: expired is combinational from the count; it is high on the TIMEOUT-th enabled cycle.
// Backpressure: none.
// Ports: clk, rst (sync, active high), clear (restart), enable (count), expired.
module ram_phase_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // High on the edge at which the count would reach TIMEOUT, so the owner
    // leaves the phase after exactly TIMEOUT cycles in it.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_master.sv
// Initiator for the change-detect RAM: one request at a time, response-fall-then-rise acknowledge.
// Latency: accept edge to rsp_valid sampled = 3 cycles, 5 when a perturb cycle is needed.
// Backpressure: req_ready only in IDLE; requests outside IDLE are ignored, nothing is queued.
// Ports: clk, rst (sync, active high), bus (ram_master_if.master: req_*, rsp_*, ram_*).
module ram_master
    import ram_if_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_master_if.master bus
);

    state_t state, state_next;

    logic [DATA_W-1:0] ram_data_q, ram_data_next;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_next;
    logic              ram_wr_q, ram_wr_next;
    logic              load_ram;

    logic [DATA_W-1:0] cap_wdata;
    logic              cap_wr;
    logic              capture;

    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_next;
    logic              rsp_err_q, rsp_err_next;
    logic              load_rsp;

    logic timer_clr, timer_en, timer_exp;

    // The RAM outputs are only ever changed on a load, so they always hold
    // exactly what the RAM last saw: they double as the last_data/last_wr
    // shadow used to guarantee a visible change on every new request.
    logic [DATA_W-1:0] last_data;
    logic              last_wr;
    assign last_data = ram_data_q;
    assign last_wr   = ram_wr_q;

    assign timer_en  = is_wait_state(state);
    assign timer_clr = (state_next != state);

    ram_phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ram_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            cap_wdata   <= '0;
            cap_wr      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_ram) begin
                ram_data_q <= ram_data_next;
                ram_addr_q <= ram_addr_next;
                ram_wr_q   <= ram_wr_next;
            end
            if (capture) begin
                cap_wdata <= bus.req_wdata;
                cap_wr    <= bus.req_wr;
            end
            if (load_rsp) begin
                rsp_rdata_q <= rsp_rdata_next;
                rsp_err_q   <= rsp_err_next;
            end
        end
    end

    always_comb begin
        state_next     = state;
        load_ram       = 1'b0;
        ram_data_next  = ram_data_q;
        ram_addr_next  = ram_addr_q;
        ram_wr_next    = ram_wr_q;
        capture        = 1'b0;
        load_rsp       = 1'b0;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    capture       = 1'b1;
                    load_ram      = 1'b1;
                    ram_addr_next = bus.req_addr;
                    if (!bus.req_wr) begin
                        // Inverting the shadow guarantees a data change.
                        ram_wr_next   = 1'b0;
                        ram_data_next = ~last_data;
                        state_next    = W_LOW;
                    end else if ((bus.req_wdata != last_data) || !last_wr) begin
                        ram_wr_next   = 1'b1;
                        ram_data_next = bus.req_wdata;
                        state_next    = W_LOW;
                    end else begin
                        // Identical write would be invisible to the RAM:
                        // issue a dummy read of inverted data first.
                        ram_wr_next   = 1'b0;
                        ram_data_next = ~bus.req_wdata;
                        state_next    = P_LOW;
                    end
                end
            end

            P_LOW: begin
                if (bus.ram_response == RAM_RESP_BUSY) begin
                    state_next = P_HIGH;
                end else if (timer_exp) begin
                    load_ram   = 1'b0;
                    load_rsp   = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next = RESP;
                end
            end

            P_HIGH: begin
                if (bus.ram_response == RAM_RESP_DONE) begin
                    load_ram      = 1'b1;
                    ram_wr_next   = 1'b1;
                    ram_data_next = cap_wdata;
                    state_next    = W_LOW;
                end else if (timer_exp) begin
                    load_rsp     = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next   = RESP;
                end
            end

            W_LOW: begin
                // A high level here is left over from the previous
                // operation; only the fall means our request was latched.
                if (bus.ram_response == RAM_RESP_BUSY) begin
                    state_next = W_HIGH;
                end else if (timer_exp) begin
                    load_rsp     = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next   = RESP;
                end
            end

            W_HIGH: begin
                if (bus.ram_response == RAM_RESP_DONE) begin
                    load_rsp       = 1'b1;
                    rsp_rdata_next = cap_wr ? '0 : bus.ram_out;
                    state_next     = RESP;
                end else if (timer_exp) begin
                    load_rsp     = 1'b1;
                    rsp_err_next = 1'b1;
                    state_next   = RESP;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: directed requests, a behavioural change-detect RAM,
// and a scoreboard monitor that checks every rsp_valid against queued expectations.
module tb_ram_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_master #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural RAM ----------------
    // Samples on negedge; a change in data or wr is latched (response
    // falls), and the operation is performed on the next negedge
    // (response rises). 'stuck' pins response high.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] lat_data = '0;
    logic          lat_wr   = 1'b0;
    logic [3:0]    lat_addr = '0;
    bit            busy     = 1'b0;
    bit            stuck    = 1'b0;
    logic          m_resp   = 1'b1;
    logic [DW-1:0] m_out    = '0;

    assign bus.ram_response = m_resp;
    assign bus.ram_out      = m_out;

    always @(negedge clk) begin
        if (stuck) begin
            m_resp = 1'b1;
        end else if (busy) begin
            if (lat_wr) mem[lat_addr] = lat_data;
            else        m_out = mem[lat_addr];
            m_resp = 1'b1;
            busy   = 1'b0;
        end else if ((bus.ram_data != lat_data) || (bus.ram_wr != lat_wr)) begin
            lat_data = bus.ram_data;
            lat_wr   = bus.ram_wr;
            lat_addr = bus.ram_addr[3:0];
            busy     = 1'b1;
            m_resp   = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string         name;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Latency is counted in edges: the consumer samples rsp_valid on the
    // posedge following this negedge, i.e. edge index cyc+1, accept at acc.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h err=%b, required no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, 32'(bus.rsp_err), 32'(mon_e.err));
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a negedge; returns just after the negedge that
    // follows the accept edge, with 'seen' = ram_data loaded at accept.
    task automatic do_req(input string nm, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                          input bit exp_err, input int exp_lat, input bit push,
                          input bit hold, output logic [DW-1:0] seen);
        int   k;
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        k = 0;
        while (!bus.req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, required 1", nm, k);
            bus.req_valid = 1'b0;
            seen = '0;
            return;
        end
        if (push) begin
            e.name  = nm;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.acc   = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        seen = bus.ram_data;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    logic [DW-1:0] seen, seen_r1, seen_r2;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset held for two cycles; values checked while still in reset.
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_ram_data", bus.ram_data, 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);

        // Write then read back.
        do_req("w5", 1, 5, 32'hDEADBEEF, 0, 0, 3, 1, 0, seen);
        do_req("r5", 0, 5, 0, 32'hDEADBEEF, 0, 3, 1, 0, seen);
        drain("t1");

        // Same data written twice in a row: second one needs the perturb.
        do_req("w7", 1, 7, 32'h1234, 0, 0, 3, 1, 0, seen);
        do_req("w8_perturb", 1, 8, 32'h1234, 0, 0, 5, 1, 0, seen);
        do_req("r7", 0, 7, 0, 32'h1234, 0, 3, 1, 0, seen);
        do_req("r8", 0, 8, 0, 32'h1234, 0, 3, 1, 0, seen);
        drain("t2");

        // Back-to-back reads: data bus must toggle between them.
        do_req("w1", 1, 1, 32'hA, 0, 0, 3, 1, 0, seen);
        do_req("w2", 1, 2, 32'hB, 0, 0, 3, 1, 0, seen);
        do_req("r1", 0, 1, 0, 32'hA, 0, 3, 1, 0, seen_r1);
        do_req("r2", 0, 2, 0, 32'hB, 0, 3, 1, 0, seen_r2);
        check("r1_ram_data", seen_r1, 32'hFFFFFFF4);
        check("r2_ram_data", seen_r2, 32'h0000000B);
        drain("t3");

        // req_valid left high with junk while busy; only IDLE-edge requests count.
        do_req("w10", 1, 10, 32'h77, 0, 0, 3, 1, 1, seen);
        for (int k = 0; k < 50 && !bus.req_ready; k++) begin
            bus.req_wr    = 1'b0;
            bus.req_addr  = AW'(11 + k);
            bus.req_wdata = 32'h5555_0000 + 32'(k);
            @(negedge clk);
        end
        do_req("r10", 0, 10, 0, 32'h77, 0, 3, 1, 0, seen);
        drain("t6");

        // RAM never drops response: timeout after TO cycles in W_LOW.
        stuck = 1'b1;
        do_req("r5_timeout", 0, 5, 0, 0, 1, TO + 1, 1, 0, seen);
        drain("t4");
        @(negedge clk);
        check("timeout_req_ready", 32'(bus.req_ready), 32'd1);
        stuck = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while in W_HIGH: no response for the aborted read.
        do_req("r5_abort", 0, 5, 0, 0, 0, 0, 0, 0, seen);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ram_data", bus.ram_data, 32'd0);
        check("abort_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        // Shadow wr is 0 after reset, so the first write of 0 is a real change;
        // repeating it hits the perturb path.
        do_req("w3_zero", 1, 3, 32'h0, 0, 0, 3, 1, 0, seen);
        do_req("w3_zero_perturb", 1, 3, 32'h0, 0, 0, 5, 1, 0, seen);
        do_req("r3", 0, 3, 0, 32'h0, 0, 3, 1, 0, seen);
        drain("t5");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
